mc_bridge_driver: RTL

//   Receiving end of the 5-bit motor-controller command word (MC[1:0] direction, MC[4:2] power)

---
 rtl/mc_bridge_driver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mc_bridge_driver.sv
// mc_bridge_driver
//   Receiving end of the 5-bit motor-controller command word. Decodes the direction field into
//   H-bridge leg controls, gates the enable with a PWM derived from the power field, and inserts
//   a fixed all-off dead-time on every exit from a driven state so the bridge cannot shoot through.
//
// Ports
//   CLK    in   1  system clock, rising edge
//   RST_N  in   1  synchronous reset, active low
//   MC     in   5  command: [1:0] 00 fwd, 01 neutral, 10 rev, 11 invalid (neutral); [4:2] power
//   HB_A   out  1  bridge leg A high (forward)
//   HB_B   out  1  bridge leg B high (reverse)
//   HB_EN  out  1  PWM-gated bridge enable
//   STATE  out  2  00 COAST, 01 FWD, 10 REV, 11 DEAD
//   BUSY   out  1  high while in DEAD
module mc_bridge_driver #(
    parameter int unsigned PWM_DIV     = 4,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] MC,
    output logic       HB_A,
    output logic       HB_B,
    output logic       HB_EN,
    output logic [1:0] STATE,
    output logic       BUSY
);

    localparam int unsigned DivW  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned DeadW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DivW-1:0]  DivLast  = DivW'(PWM_DIV - 1);
    localparam logic [DeadW-1:0] DeadLoad = DeadW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        StCoast = 2'b00,
        StFwd   = 2'b01,
        StRev   = 2'b10,
        StDead  = 2'b11
    } state_e;

    // Input stage and PWM datapath
    logic [4:0]      mc_q;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      slice_q, slice_d;
    logic [2:0]      duty_q, duty_d;
    logic            div_wrap, period_wrap, pwm_on_d;

    // FSM
    state_e           state_q, state_d;
    logic [DeadW-1:0] dead_q, dead_d;
    logic             hb_a_q, hb_a_d;
    logic             hb_b_q, hb_b_d;
    logic             hb_en_q, hb_en_d;
    logic             busy_q, busy_d;
    logic             dir_fwd, dir_rev;

    assign dir_fwd = (mc_q[1:0] == 2'b00);
    assign dir_rev = (mc_q[1:0] == 2'b10);

    always_comb begin
        div_wrap    = (div_q == DivLast);
        period_wrap = div_wrap && (slice_q == 3'd7);
        div_d       = div_wrap ? '0 : div_q + 1'b1;
        slice_d     = div_wrap ? slice_q + 3'd1 : slice_q;
        // Duty only changes on a period boundary, so a pulse is never cut short or stretched.
        duty_d      = period_wrap ? mc_q[4:2] : duty_q;
        // Evaluated on next-cycle counter values so the registered enable lines up with slice 0.
        pwm_on_d    = (slice_d <= duty_d);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mc_q    <= 5'b00001;
            div_q   <= '0;
            slice_q <= '0;
            duty_q  <= '0;
        end else begin
            mc_q    <= MC;
            div_q   <= div_d;
            slice_q <= slice_d;
            duty_q  <= duty_d;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StCoast;
            dead_q  <= '0;
            hb_a_q  <= 1'b0;
            hb_b_q  <= 1'b0;
            hb_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dead_q  <= dead_d;
            hb_a_q  <= hb_a_d;
            hb_b_q  <= hb_b_d;
            hb_en_q <= hb_en_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        unique case (state_q)
            StCoast: begin
                if (dir_fwd) begin
                    state_d = StFwd;
                end else if (dir_rev) begin
                    state_d = StRev;
                end
            end
            StFwd: begin
                if (!dir_fwd) begin
                    state_d = StDead;
                    dead_d  = DeadLoad;
                end
            end
            StRev: begin
                if (!dir_rev) begin
                    state_d = StDead;
                    dead_d  = DeadLoad;
                end
            end
            StDead: begin
                // Exit target comes from the command present now, not the one that caused DEAD.
                if (dead_q == '0) begin
                    if (dir_fwd) begin
                        state_d = StFwd;
                    end else if (dir_rev) begin
                        state_d = StRev;
                    end else begin
                        state_d = StCoast;
                    end
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            default: begin
                state_d = StCoast;
            end
        endcase
    end

    // Output logic, registered alongside the state
    always_comb begin
        hb_a_d  = 1'b0;
        hb_b_d  = 1'b0;
        hb_en_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state_d)
            StFwd: begin
                hb_a_d  = 1'b1;
                hb_en_d = pwm_on_d;
            end
            StRev: begin
                hb_b_d  = 1'b1;
                hb_en_d = pwm_on_d;
            end
            StDead: begin
                busy_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign HB_A  = hb_a_q;
    assign HB_B  = hb_b_q;
    assign HB_EN = hb_en_q;
    assign STATE = state_q;
    assign BUSY  = busy_q;

endmodule
